// File: rtl/clk_div_defs.sv
// -----------------------------------------------------------------------------
// clk_div_defs
// Shared constants for the clock divider bank.
//   CLK_HZ        : input clock frequency in Hz
//   DIV_SCAN_50K  : divisor that gives a true 50 kHz from CLK_HZ (display scan)
//   DIV_MIN       : smallest legal divisor; smaller writes saturate to this
//   div_for_hz(f) : divisor (full period in input clocks) for output freq f
// -----------------------------------------------------------------------------
package clk_div_defs;

  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned DIV_SCAN_50K = 2000;
  localparam int unsigned DIV_MIN      = 2;

  // A zero request returns 0 rather than dividing by zero; callers treat 0 as
  // "not a usable divisor" and the bank saturates it to DIV_MIN anyway.
  function automatic int unsigned div_for_hz(input int unsigned f);
    return (f == 0) ? 0 : (CLK_HZ / f);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active divisor, pending divisor, square wave
// and one-cycle tick.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   en           : channel enable; low holds the counter and outputs at 0
//   wr           : divisor write strobe for this channel (already decoded)
//   wr_val       : divisor to write (already saturated to the legal minimum)
//   clk_out      : registered square wave, high H=(D+1)>>1 of every D cycles
//   tick         : one-cycle pulse coincident with cnt == 0 after a wrap
//   pend         : a written divisor waits for the next wrap
//   div_cur      : active divisor D
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_defs::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = int'(DIV_SCAN_50K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pend,
  output logic [CNT_W-1:0] div_cur
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]   half;

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clk_out_d  = clk_out_q;
    tick_d     = tick_q;

    wrap  = (cnt_q == (div_q - CNT_W'(1)));
    cnt_n = wrap ? '0 : (cnt_q + CNT_W'(1));
    // One extra bit so D = 2^CNT_W-1 does not overflow when rounding up.
    half  = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;

    if (!en) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      // No period is running, so there is no boundary to wait for.
      if (wr) begin
        div_d  = wr_val;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = pend_val_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d     = cnt_n;
      clk_out_d = ({1'b0, cnt_n} < half);
      tick_d    = wrap;
      if (wrap) begin
        // A write landing on the wrap edge is newer than any pending value.
        if (wr) begin
          div_d = wr_val;
        end else if (pend_q) begin
          div_d = pend_val_q;
        end
        pend_d = 1'b0;
      end else if (wr) begin
        pend_val_d = wr_val;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEF_DIV);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;
  assign div_cur = div_q;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH independent runtime-programmable clock dividers. Each channel
// yields a registered square wave and a one-cycle tick per period of D input
// clocks. New divisors take effect only at a period boundary.
// Ports:
//   clk_100M  : system clock
//   rst_n     : asynchronous active-low reset
//   ch_en     : per-channel enable
//   cfg_we    : divisor write strobe
//   cfg_sel   : target channel; values >= NUM_CH are ignored
//   cfg_div   : new divisor; values below MIN_DIV saturate to MIN_DIV
//   clk_out   : per-channel divided clock (fabric signal, not a global clock)
//   tick      : per-channel one-cycle pulse, once per period
//   cfg_pend  : per-channel "written divisor waits for next wrap"
//   div_cur   : active divisors, channel i at [i*CNT_W +: CNT_W]
//
// Config interface: cfg_we is a single-cycle strobe with no ready/back-pressure;
// every strobe with a valid cfg_sel is accepted on the edge that samples it.
// -----------------------------------------------------------------------------
module clk_div_bank
  import clk_div_defs::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 16,
  parameter  int DEF_DIV = int'(DIV_SCAN_50K),
  parameter  int MIN_DIV = int'(DIV_MIN),
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_100M,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    cfg_we,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic [CNT_W-1:0]        cfg_div,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pend,
  output logic [NUM_CH*CNT_W-1:0] div_cur
);

  logic [NUM_CH-1:0] wr_vec;
  logic [CNT_W-1:0]  wr_val;

  always_comb begin
    wr_val = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
    // A select beyond the last channel matches no index, so the write is
    // dropped without touching any channel.
    wr_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_vec[i] = cfg_we && (32'(cfg_sel) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk_100M),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .wr      (wr_vec[g]),
      .wr_val  (wr_val),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (cfg_pend[g]),
      .div_cur (div_cur[g*CNT_W +: CNT_W])
    );
  end

endmodule
